// File: rtl/board_frame_serializer.sv
// Serialises a stable snapshot of the 32-bit playfield word MSB first to a display shift-register
// chain (serial clock / data / latch), refreshing on request or when the board changes in auto mode.
module board_frame_serializer #(
   parameter int ROWS     = 8,
   parameter int COLS     = 4,
   parameter int SCLK_DIV = 2
) (
   input  logic            in_clka,
   input  logic            in_restart,
   input  logic [31:0]     in_board,
   input  logic            in_frame_req,
   input  logic            in_auto,
   output logic            out_sclk,
   output logic            out_sdata,
   output logic            out_latch,
   output logic            out_busy,
   output logic [ROWS-1:0] out_row_full,
   output logic [7:0]      out_frame_cnt
);
   typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;

   localparam logic [3:0] DIV_LAST = 4'(SCLK_DIV - 1);

   state_t          state_reg;
   logic [31:0]     snap_reg;
   logic [31:0]     last_sent_reg;
   logic [4:0]      bit_idx_reg;
   logic [3:0]      div_cnt_reg;
   logic            pending_reg;
   logic [ROWS-1:0] row_full_next;
   logic            trigger;
   logic            phase_done;

   generate
      for (genvar gi = 0; gi < ROWS; gi++) begin : g_row_full
         assign row_full_next[gi] = &in_board[gi*COLS +: COLS];
      end
   endgenerate

   assign trigger    = in_frame_req | pending_reg | (in_auto & (in_board != last_sent_reg));
   assign phase_done = (div_cnt_reg == DIV_LAST);

   always_ff @(posedge in_clka or posedge in_restart) begin
      if (in_restart) begin
         state_reg     <= IDLE;
         snap_reg      <= '0;
         last_sent_reg <= '0;
         bit_idx_reg   <= '0;
         div_cnt_reg   <= '0;
         pending_reg   <= 1'b0;
         out_sclk      <= 1'b0;
         out_sdata     <= 1'b0;
         out_latch     <= 1'b0;
         out_busy      <= 1'b0;
         out_row_full  <= '0;
         out_frame_cnt <= '0;
      end else begin
         // A request arriving mid-frame is remembered once and served right after this frame.
         if (state_reg != IDLE && in_frame_req)
            pending_reg <= 1'b1;

         case (state_reg)
            IDLE: begin
               if (trigger) begin
                  snap_reg      <= in_board;
                  last_sent_reg <= in_board;
                  out_row_full  <= row_full_next;
                  bit_idx_reg   <= 5'd31;
                  div_cnt_reg   <= '0;
                  pending_reg   <= 1'b0;
                  out_busy      <= 1'b1;
                  out_sclk      <= 1'b0;
                  out_sdata     <= in_board[31];
                  state_reg     <= SHIFT_LO;
               end
            end
            SHIFT_LO: begin
               if (phase_done) begin
                  div_cnt_reg <= '0;
                  out_sclk    <= 1'b1;
                  state_reg   <= SHIFT_HI;
               end else begin
                  div_cnt_reg <= div_cnt_reg + 4'd1;
               end
            end
            SHIFT_HI: begin
               if (phase_done) begin
                  div_cnt_reg <= '0;
                  out_sclk    <= 1'b0;
                  if (bit_idx_reg == 5'd0) begin
                     out_sdata <= 1'b0;
                     out_latch <= 1'b1;
                     state_reg <= LATCH;
                  end else begin
                     bit_idx_reg <= bit_idx_reg - 5'd1;
                     out_sdata   <= snap_reg[bit_idx_reg - 5'd1];
                     state_reg   <= SHIFT_LO;
                  end
               end else begin
                  div_cnt_reg <= div_cnt_reg + 4'd1;
               end
            end
            LATCH: begin
               out_latch     <= 1'b0;
               out_busy      <= 1'b0;
               out_frame_cnt <= out_frame_cnt + 8'd1;
               state_reg     <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_board_frame_serializer.sv
// Directed bench: one serializer at SCLK_DIV=1 for framing/auto/pending/reset cases and one at
// SCLK_DIV=3 for phase lengths, frame span and frame counter wrap.
module tb_board_frame_serializer;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        a_rst = 1'b1, a_req = 1'b0, a_auto = 1'b0;
   logic [31:0] a_board = '0;
   logic        a_sclk, a_sdata, a_latch, a_busy;
   logic [7:0]  a_row_full, a_cnt;

   logic        b_rst = 1'b1, b_req = 1'b0, b_auto = 1'b0;
   logic [31:0] b_board = '0;
   logic        b_sclk, b_sdata, b_latch, b_busy;
   logic [7:0]  b_row_full, b_cnt;

   board_frame_serializer #(.ROWS(8), .COLS(4), .SCLK_DIV(1)) dut_a (
      .in_clka(clk), .in_restart(a_rst), .in_board(a_board), .in_frame_req(a_req),
      .in_auto(a_auto), .out_sclk(a_sclk), .out_sdata(a_sdata), .out_latch(a_latch),
      .out_busy(a_busy), .out_row_full(a_row_full), .out_frame_cnt(a_cnt));

   board_frame_serializer #(.ROWS(8), .COLS(4), .SCLK_DIV(3)) dut_b (
      .in_clka(clk), .in_restart(b_rst), .in_board(b_board), .in_frame_req(b_req),
      .in_auto(b_auto), .out_sclk(b_sclk), .out_sdata(b_sdata), .out_latch(b_latch),
      .out_busy(b_busy), .out_row_full(b_row_full), .out_frame_cnt(b_cnt));

   // Serial receiver model for dut_a: shifts in data on each sclk rise, counts latch pulses.
   logic        a_sclk_prev = 1'b0;
   logic [31:0] a_shreg = '0;
   int          a_rises = 0;
   int          a_latches = 0;
   always @(negedge clk) begin
      if (a_sclk === 1'b1 && a_sclk_prev === 1'b0) begin
         a_shreg <= {a_shreg[30:0], a_sdata};
         a_rises <= a_rises + 1;
      end
      if (a_latch === 1'b1) a_latches <= a_latches + 1;
      a_sclk_prev <= a_sclk;
   end

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("[%0t] check %s observed=%0h expected=%0h", $time, tag, obs, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic wait_latch_a(input int limit, output int cyc);
      cyc = 0;
      while (a_latch !== 1'b1 && cyc < limit) begin
         step(1);
         cyc++;
      end
   endtask

   int cyc, n, mism, base_l, base_r;
   logic exp_sclk;

   initial begin
      // Reset state
      step(2);
      check("reset_outputs_a", {18'd0, a_sclk, a_sdata, a_latch, a_busy, a_row_full, a_cnt}, 32'd0);
      check("reset_outputs_b", {18'd0, b_sclk, b_sdata, b_latch, b_busy, b_row_full, b_cnt}, 32'd0);
      a_rst = 1'b0; b_rst = 1'b0;
      step(1);

      // Single frame, SCLK_DIV=1
      base_r = a_rises;
      a_board = 32'hF0A5000F; a_req = 1'b1;
      step(1); a_req = 1'b0;
      check("first_busy", a_busy, 1);
      check("first_sdata_bit31", a_sdata, 1);
      wait_latch_a(200, cyc);
      check("latch_cycle", cyc + 1, 65);
      check("frame1_bits", a_shreg, 32'hF0A5000F);
      check("frame1_rises", a_rises - base_r, 32);
      check("frame1_row_full", a_row_full, 8'b1000_0001);
      step(1);
      check("frame1_idle_busy", a_busy, 0);
      check("frame1_cnt", a_cnt, 1);

      // Auto mode from fresh reset
      a_rst = 1'b1; step(2); a_rst = 1'b0;
      base_l = a_latches;
      a_board = 32'h00000001; a_auto = 1'b1;
      step(150);
      check("auto1_latches", a_latches - base_l, 1);
      check("auto1_bits", a_shreg, 32'h00000001);
      check("auto1_cnt", a_cnt, 1);
      a_board = 32'h00000003;
      step(150);
      check("auto2_bits", a_shreg, 32'h00000003);
      check("auto2_cnt", a_cnt, 2);
      step(150);
      check("auto_hold_latches", a_latches - base_l, 2);
      a_auto = 1'b0;

      // Snapshot isolation and pending request
      a_board = 32'h12345678; a_req = 1'b1;
      step(1); a_req = 1'b0;
      check("snap_bit31", a_sdata, 0);
      step(22);
      check("snap_bit20", a_sdata, 1);
      a_board = 32'hFFFFFFFF; a_req = 1'b1;
      step(1); a_req = 1'b0;
      wait_latch_a(100, cyc);
      check("snap_latch_cycle", cyc + 24, 65);
      check("snap_bits", a_shreg, 32'h12345678);
      check("snap_row_full", a_row_full, 8'h00);
      step(1);
      check("pending_idle_gap", a_busy, 0);
      step(1);
      check("pending_capture", a_busy, 1);
      check("pending_row_full", a_row_full, 8'hFF);
      wait_latch_a(100, cyc);
      check("pending_bits", a_shreg, 32'hFFFFFFFF);
      step(1);
      check("pending_cnt", a_cnt, 4);

      // Reset mid-frame
      a_board = 32'hA5A5A5A5; a_req = 1'b1;
      step(1); a_req = 1'b0;
      step(42);
      check("midframe_busy", a_busy, 1);
      a_rst = 1'b1;
      #1;
      check("async_reset_outputs", {18'd0, a_sclk, a_sdata, a_latch, a_busy, a_row_full, a_cnt}, 32'd0);
      step(2); a_rst = 1'b0;
      base_l = a_latches;
      step(80);
      check("abort_no_latch", a_latches - base_l, 0);
      check("abort_cnt", a_cnt, 0);
      base_r = a_rises;
      a_req = 1'b1;
      step(1); a_req = 1'b0;
      wait_latch_a(100, cyc);
      check("after_reset_bits", a_shreg, 32'hA5A5A5A5);
      check("after_reset_rises", a_rises - base_r, 32);
      step(1);
      check("after_reset_cnt", a_cnt, 1);

      // SCLK_DIV=3: phase lengths and frame span
      b_board = 32'h0000FFFF; b_req = 1'b1;
      step(1); b_req = 1'b0;
      mism = 0; cyc = 1;
      while (b_latch !== 1'b1 && cyc < 300) begin
         exp_sclk = (((cyc - 1) / 3) % 2) == 1;
         if (b_sclk !== exp_sclk) mism++;
         step(1);
         cyc++;
      end
      check("b_sclk_phases", mism, 0);
      check("b_latch_cycle", cyc, 193);
      step(1);
      check("b_idle_busy", b_busy, 0);
      check("b_cnt", b_cnt, 1);
      check("b_row_full", b_row_full, 8'h0F);

      // Back-to-back frames until the counter wraps
      b_req = 1'b1;
      n = 0; cyc = 0;
      while (n < 255 && cyc < 60000) begin
         step(1);
         cyc++;
         if (b_latch === 1'b1) n++;
      end
      check("b_wrap_frames", n, 255);
      check("b_wrap_cycles", cyc, 193 + 194 * 254);
      step(1);
      check("b_wrap_cnt", b_cnt, 0);
      b_req = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
